mole_round_ctrl: RTL and testbench
==================================

MOLE_ROUND_CTRL -- requirements
Module: mole_round_ctrl

Interface
REQ-001 SHALL have parameter INIT_INTERVAL, default 5; first-round interval in seconds (1..7).
REQ-002 SHALL have parameter MIN_INTERVAL, default 1; floor interval in seconds (1..INIT_INTERVAL).
REQ-003 SHALL have parameter START_LIVES, default 3; lives at game start (1..3).
REQ-004 SHALL have parameter LEVEL_HITS, default 4; hits per speed-up step.
REQ-005 SHALL have port clk, input, 1; single system clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1; synchronous, active-low reset.
REQ-007 SHALL have port start, input, 1; one-cycle pulse that begins a game.
REQ-008 SHALL have port btn, input, 4; synchronized, debounced one-cycle hit pulses, one bit per hole.
REQ-009 SHALL have port tmr_timeout, input, 1; timeout level from the downstream interval timer.
REQ-010 SHALL have port tmr_rst_n, output, 1; active-low restart to the timer.
REQ-011 SHALL have port tmr_interval, output, 3; interval driven to the timer.
REQ-012 SHALL have port tmr_dir, output, 1; timer direction, tied 0 (count down).
REQ-013 SHALL have port mole, output, 4; one-hot active hole, all-zero when no mole is up.
REQ-014 SHALL have port score, output, 8; hit count.
REQ-015 SHALL have port lives, output, 2; remaining lives.
REQ-016 SHALL have port game_over, output, 1; high in OVER.

Function
REQ-017 SHALL implement FSM states IDLE, ARM, UP, HIT, MISS, OVER.
REQ-018 IDLE: start=1 -> load score=0, lives=START_LIVES, interval=INIT_INTERVAL, hit counter=0; go to ARM.
REQ-019 ARM, exactly 1 cycle: tmr_rst_n=0; mole index latched from LFSR; go to UP.
REQ-020 SHALL set tmr_rst_n=1 in every state except ARM.
REQ-021 UP: mole = one-hot of the latched index.
REQ-022 UP, btn==mole -> HIT.
REQ-023 UP, btn nonzero and !=mole (including multi-bit) -> MISS.
REQ-024 UP, tmr_timeout=1 with btn==0 -> MISS.
REQ-025 UP: a correct btn in the same cycle as tmr_timeout SHALL be a HIT.
REQ-026 HIT, 1 cycle: score+1, saturating at 255; hit counter+1; go to ARM.
REQ-027 MISS, 1 cycle: lives-1; go to OVER if lives reaches 0, else ARM.
REQ-028 SHALL set mole=0 in HIT, MISS, ARM, IDLE and OVER.
REQ-029 OVER: game_over=1; score and lives hold; start=1 -> same initialization as REQ-018, go to ARM.
REQ-030 SHALL ignore start outside IDLE/OVER, and btn outside UP.
REQ-031 SHALL use an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'h5A, advancing every cycle.
REQ-032 Mole index = LFSR[1:0]; if it equals the previous index, index+1 mod 4 SHALL be used.
REQ-033 SHALL drive tmr_interval from the interval register at all times.

Reset
REQ-034 On rst_n=0 at a clock edge: state=IDLE, mole=0, score=0, lives=0, game_over=0.
REQ-035 On rst_n=0 at a clock edge: tmr_rst_n=0, interval=INIT_INTERVAL, LFSR=8'h5A, previous index=0, hit counter=0.
REQ-036 Reset asserted in any state, including mid-round, SHALL abort the game with no score or lives update.

Configuration
REQ-037 SHALL compile the speed-up feature only when MOLE_SPEEDUP_EN is defined.
REQ-038 With MOLE_SPEEDUP_EN: on the HIT where the hit counter reaches LEVEL_HITS, the counter clears and interval-1, floored at MIN_INTERVAL.
REQ-039 With MOLE_SPEEDUP_EN: the new interval SHALL take effect at the next ARM.
REQ-040 Without MOLE_SPEEDUP_EN: interval stays at INIT_INTERVAL and the hit counter logic is absent.

Verification
REQ-041 Reset, start pulse, then btn matching mole in UP -> score=1, lives=3, ARM with tmr_rst_n=0 for 1 cycle.
REQ-042 No btn, drive tmr_timeout=1 three rounds -> lives 3->2->1->0, game_over=1, mole=0, score held.
REQ-043 Same cycle: btn==mole and tmr_timeout=1 -> HIT; score increments, lives unchanged.
REQ-044 Wrong btn (4'b0011 vs mole 4'b0100) -> lives-1, no score change.
REQ-045 MOLE_SPEEDUP_EN, INIT_INTERVAL=2: 4 hits -> tmr_interval=1; 4 more hits -> stays 1; without the macro stays 2.
REQ-046 rst_n=0 while in UP -> next cycle IDLE, mole=0, score=0, tmr_rst_n=0; 1000 rounds never repeat a mole index back to back.

Source files
------------

// File: rtl/mole_round_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : mole_round_ctrl
// Brief   : Whack-a-mole round controller with LFSR mole placement, scoring,
//           lives and optional speed-up (compiled in with MOLE_SPEEDUP_EN).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module mole_round_ctrl #(
  parameter int INIT_INTERVAL = 5,
  parameter int MIN_INTERVAL  = 1,
  parameter int START_LIVES   = 3,
  parameter int LEVEL_HITS    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic       tmr_timeout,
  output logic       tmr_rst_n,
  output logic [2:0] tmr_interval,
  output logic       tmr_dir,
  output logic [3:0] mole,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_UP   = 3'd2;
  localparam logic [2:0] S_HIT  = 3'd3;
  localparam logic [2:0] S_MISS = 3'd4;
  localparam logic [2:0] S_OVER = 3'd5;

  if (INIT_INTERVAL < 1 || INIT_INTERVAL > 7 || MIN_INTERVAL < 1 ||
      MIN_INTERVAL > INIT_INTERVAL || START_LIVES < 1 || START_LIVES > 3 ||
      LEVEL_HITS < 1) begin : g_bad_cfg
    $error("mole_round_ctrl: parameter out of range");
  end

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       r_tmr_rst_n;
  logic [7:0] r_lfsr;
  logic [1:0] r_idx;
  logic [1:0] w_idx;
  logic [3:0] w_onehot;
  logic [7:0] r_score;
  logic [1:0] r_lives;
  logic [2:0] w_interval;
  logic       w_start_game;

  assign w_start_game = start && (r_state == S_IDLE || r_state == S_OVER);
  assign w_onehot     = 4'b0001 << r_idx;
  // Never place the mole in the same hole twice in a row.
  assign w_idx        = (r_lfsr[1:0] == r_idx) ? r_lfsr[1:0] + 2'd1 : r_lfsr[1:0];

  // State register; timer restart is registered so it is low during reset and ARM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tmr_rst_n <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_tmr_rst_n <= (w_next != S_ARM);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_OVER: if (start) w_next = S_ARM;
      S_ARM:          w_next = S_UP;
      S_UP: begin
        if (btn != 4'd0)      w_next = (btn == w_onehot) ? S_HIT : S_MISS;
        else if (tmr_timeout) w_next = S_MISS;
      end
      S_HIT:          w_next = S_ARM;
      S_MISS:         w_next = (r_lives <= 2'd1) ? S_OVER : S_ARM;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mole      = 4'd0;
    game_over = 1'b0;
    if (r_state == S_UP)   mole      = w_onehot;
    if (r_state == S_OVER) game_over = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= 8'h5A;
      r_idx  <= 2'd0;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      if (r_state == S_ARM) r_idx <= w_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_score <= 8'd0;
      r_lives <= 2'd0;
    end else if (w_start_game) begin
      r_score <= 8'd0;
      r_lives <= 2'(START_LIVES);
    end else if (r_state == S_HIT) begin
      if (r_score != 8'hFF) r_score <= r_score + 8'd1;
    end else if (r_state == S_MISS) begin
      r_lives <= r_lives - 2'd1;
    end
  end

`ifdef MOLE_SPEEDUP_EN
  localparam int c_HW = $clog2(LEVEL_HITS + 1);

  logic [c_HW-1:0] r_hits;
  logic [2:0]      r_interval;

  // The shortened interval is picked up by the timer restart in the following ARM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hits     <= '0;
      r_interval <= 3'(INIT_INTERVAL);
    end else if (w_start_game) begin
      r_hits     <= '0;
      r_interval <= 3'(INIT_INTERVAL);
    end else if (r_state == S_HIT) begin
      if (r_hits == c_HW'(LEVEL_HITS - 1)) begin
        r_hits <= '0;
        if (r_interval > 3'(MIN_INTERVAL)) r_interval <= r_interval - 3'd1;
      end else begin
        r_hits <= r_hits + 1'b1;
      end
    end
  end

  assign w_interval = r_interval;
`else
  assign w_interval = 3'(INIT_INTERVAL);
`endif

  assign tmr_rst_n    = r_tmr_rst_n;
  assign tmr_interval = w_interval;
  assign tmr_dir      = 1'b0;
  assign score        = r_score;
  assign lives        = r_lives;

endmodule
`default_nettype wire

// File: tb/tb_mole_round_ctrl.sv
`default_nettype none
// Directed self-checking bench for mole_round_ctrl (INIT_INTERVAL=2 build).
module tb_mole_round_ctrl;
  localparam int INIT_INTERVAL = 2;
  localparam int MIN_INTERVAL  = 1;
  localparam int START_LIVES   = 3;
  localparam int LEVEL_HITS    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn = 4'd0;
  logic       tmr_timeout = 1'b0;
  logic       tmr_rst_n;
  logic [2:0] tmr_interval;
  logic       tmr_dir;
  logic [3:0] mole;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_score, exp_lives, exp_int, exp_hits;
  logic [1:0] m_prev;
  logic [7:0] m_lfsr;

  mole_round_ctrl #(
    .INIT_INTERVAL(INIT_INTERVAL),
    .MIN_INTERVAL (MIN_INTERVAL),
    .START_LIVES  (START_LIVES),
    .LEVEL_HITS   (LEVEL_HITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .btn         (btn),
    .tmr_timeout (tmr_timeout),
    .tmr_rst_n   (tmr_rst_n),
    .tmr_interval(tmr_interval),
    .tmr_dir     (tmr_dir),
    .mole        (mole),
    .score       (score),
    .lives       (lives),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 8'h5A, steps every cycle.
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 8'h5A;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_score = 0;
    exp_lives = START_LIVES;
    exp_int   = INIT_INTERVAL;
    exp_hits  = 0;
    chk("start_score", score, 0);
    chk("start_lives", lives, START_LIVES);
    chk("start_over", game_over, 0);
  endtask

  // Entry at the negedge inside ARM. mode: 0 correct, 1 wrong, 2 multi-bit, 3 timeout only.
  task automatic play_round(input int mode, input bit with_to, input bit poke);
    logic [1:0] raw, idx;
    logic [3:0] oh, b;
    chk("arm_tmr_rst_n", tmr_rst_n, 0);
    chk("arm_mole", mole, 0);
    raw = m_lfsr[1:0];
    idx = (raw == m_prev) ? raw + 2'd1 : raw;
    oh  = 4'b0001 << idx;
    m_prev = idx;
    @(negedge clk);
    chk("up_mole", mole, oh);
    chk("up_tmr_rst_n", tmr_rst_n, 1);
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("up_start_ignored", mole, oh);
    end
    case (mode)
      0:       b = oh;
      1:       b = {oh[2:0], oh[3]};
      2:       b = oh | {oh[2:0], oh[3]};
      default: b = 4'd0;
    endcase
    btn = b;
    tmr_timeout = with_to;
    @(negedge clk);
    btn = 4'd0;
    tmr_timeout = 1'b0;
    chk("resolve_mole", mole, 0);
    @(negedge clk);
    if (mode == 0) begin
      if (exp_score < 255) exp_score++;
`ifdef MOLE_SPEEDUP_EN
      exp_hits++;
      if (exp_hits == LEVEL_HITS) begin
        exp_hits = 0;
        if (exp_int > MIN_INTERVAL) exp_int--;
      end
`endif
    end else begin
      exp_lives--;
    end
    chk("score", score, exp_score);
    chk("lives", lives, exp_lives);
    chk("game_over", game_over, (exp_lives == 0) ? 1 : 0);
    chk("interval", tmr_interval, exp_int);
  endtask

  initial begin
    m_prev = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_mole", mole, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_tmr_rst_n", tmr_rst_n, 0);
    chk("rst_interval", tmr_interval, INIT_INTERVAL);
    chk("tmr_dir", tmr_dir, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_tmr_rst_n", tmr_rst_n, 1);
    btn = 4'b0001;
    @(negedge clk);
    btn = 4'd0;
    chk("idle_btn_ignored", tmr_rst_n, 1);
    chk("idle_btn_mole", mole, 0);

    start_game();
    play_round(0, 1'b0, 1'b1);  // plain hit, start pulse ignored in UP
    play_round(0, 1'b1, 1'b0);  // hit coinciding with timeout
    play_round(1, 1'b0, 1'b0);  // wrong hole
    play_round(2, 1'b0, 1'b0);  // multi-bit press
    play_round(3, 1'b1, 1'b0);  // timeout, last life
    btn = 4'hF;
    @(negedge clk);
    btn = 4'd0;
    chk("over_hold", game_over, 1);
    chk("over_mole", mole, 0);
    chk("over_score", score, exp_score);
    chk("over_tmr_rst_n", tmr_rst_n, 1);

    start_game();
    for (int i = 0; i < 8; i++) play_round(0, 1'b0, 1'b0);
    play_round(3, 1'b1, 1'b0);
    chk("after_miss_interval", tmr_interval, exp_int);

    @(negedge clk);
    chk("mid_up_mole_on", (mole != 4'd0) ? 1 : 0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_mole", mole, 0);
    chk("midrst_score", score, 0);
    chk("midrst_lives", lives, 0);
    chk("midrst_tmr_rst_n", tmr_rst_n, 0);
    chk("midrst_game_over", game_over, 0);
    chk("midrst_interval", tmr_interval, INIT_INTERVAL);
    rst_n  = 1'b1;
    m_prev = 2'd0;
    @(negedge clk);
    chk("midrst_idle", tmr_rst_n, 1);

    start_game();
    for (int i = 0; i < 1000; i++) play_round(0, 1'b0, 1'b0);
    chk("score_saturated", score, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
